// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 window convolution slice.
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUT,
    ST_DONE
  } state_t;

  localparam int unsigned TAPS   = 9;
  localparam int unsigned PHASES = 5;

  localparam int unsigned DEF_IMG_W = 14;
  localparam int unsigned DEF_IMG_H = 14;
  localparam int unsigned DEF_ACC_W = 20;

  // Row/column offset of each tap inside the window, row-major.
  localparam logic [1:0] TAP_ROW_OFS [TAPS] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
  localparam logic [1:0] TAP_COL_OFS [TAPS] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};

endpackage

// File: rtl/conv_pair_mac.sv
// Two signed 8x8 multiplies, products sign-extended and summed at ACC_W.
module conv_pair_mac
  import conv_pkg::*;
#(
  parameter int unsigned ACC_W = DEF_ACC_W
) (
  input  logic signed [7:0]       i_a,
  input  logic signed [7:0]       i_b,
  input  logic signed [7:0]       i_wa,
  input  logic signed [7:0]       i_wb,
  output logic signed [ACC_W-1:0] o_sum
);

  logic signed [15:0] w_pa;
  logic signed [15:0] w_pb;

  assign w_pa  = i_a * i_wa;
  assign w_pb  = i_b * i_wb;
  assign o_sum = {{(ACC_W-16){w_pa[15]}}, w_pa} + {{(ACC_W-16){w_pb[15]}}, w_pb};

endmodule

// File: rtl/conv3x3_window_mac.sv
// 3x3 convolution walker over a single-channel image in a dual-read memory.
// Issues two tap reads per cycle (5 phases), accumulates one phase behind,
// presents one result per window on a valid/ready handshake.
// Optional macro CONV_RELU_EN: clamp negative results to zero.
module conv3x3_window_mac
  import conv_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [71:0]       weights,
  output logic              busy,
  output logic              done,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [ADDR_W-1:0] mem_addr2,
  input  logic [7:0]        mem_dout1,
  input  logic [7:0]        mem_dout2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [7:0]        out_idx
);

  state_t                   r_state;
  logic [2:0]               r_phase;
  logic [7:0]               r_row;
  logic [7:0]               r_col;
  logic [7:0]               r_idx;
  logic [71:0]              r_w;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_load;
  logic [ADDR_W-1:0]        r_addr1;
  logic [ADDR_W-1:0]        r_addr2;
  logic                     r_valid;
  logic [ACC_W-1:0]         r_out;
  logic [7:0]               r_oidx;

  logic [2:0]               w_phase_nx;
  logic [3:0]               w_ka_nx;
  logic [3:0]               w_kb_nx;
  logic                     w_col_wrap;
  logic                     w_last;
  logic [7:0]               w_col_nx;
  logic [7:0]               w_row_nx;
  logic [2:0]               w_dphase;
  logic                     w_b_zero;
  logic [3:0]               w_ka_d;
  logic [3:0]               w_kb_d;
  logic [7:0]               w_wa;
  logic [7:0]               w_wb;
  logic signed [ACC_W-1:0]  w_pair;
  logic signed [ACC_W-1:0]  w_acc_nx;
  logic [ACC_W-1:0]         w_result;

  function automatic logic [ADDR_W-1:0] tap_addr(input logic [7:0] row, input logic [7:0] col,
                                                 input logic [3:0] k);
    logic [ADDR_W-1:0] v_r;
    logic [ADDR_W-1:0] v_c;
    v_r = ADDR_W'(row) + ADDR_W'(TAP_ROW_OFS[k]);
    v_c = ADDR_W'(col) + ADDR_W'(TAP_COL_OFS[k]);
    return ADDR_W'(v_r * ADDR_W'(IMG_W)) + v_c;
  endfunction

  // Tap pair for the phase about to be issued; the last phase reads tap 8 twice.
  assign w_phase_nx = r_phase + 3'd1;
  assign w_ka_nx    = {w_phase_nx, 1'b0};
  assign w_kb_nx    = (w_phase_nx == 3'(PHASES-1)) ? w_ka_nx : w_ka_nx + 4'd1;

  assign w_col_wrap = (r_col == 8'(IMG_W-3));
  assign w_last     = w_col_wrap && (r_row == 8'(IMG_H-3));
  assign w_col_nx   = w_col_wrap ? '0 : r_col + 8'd1;
  assign w_row_nx   = w_col_wrap ? r_row + 8'd1 : r_row;

  // Returning data belongs to the previous phase; in DRAIN it is the last phase,
  // whose second read is a duplicate and must contribute nothing.
  assign w_dphase = (r_state == ST_DRAIN) ? 3'(PHASES-1) : r_phase - 3'd1;
  assign w_b_zero = (w_dphase == 3'(PHASES-1));
  assign w_ka_d   = {w_dphase, 1'b0};
  assign w_kb_d   = w_b_zero ? w_ka_d : w_ka_d + 4'd1;
  assign w_wa     = r_w[{w_ka_d, 3'b000} +: 8];
  assign w_wb     = w_b_zero ? '0 : r_w[{w_kb_d, 3'b000} +: 8];

  conv_pair_mac #(.ACC_W(ACC_W)) u_pair_mac (
    .i_a   (mem_dout1),
    .i_b   (mem_dout2),
    .i_wa  (w_wa),
    .i_wb  (w_wb),
    .o_sum (w_pair)
  );

  assign w_acc_nx = r_acc + w_pair;

  // Result register input: raw accumulator or clamped at zero.
  always_comb begin
`ifdef CONV_RELU_EN
    w_result = w_acc_nx[ACC_W-1] ? '0 : w_acc_nx;
`else
    w_result = w_acc_nx;
`endif
  end

  // Accumulator: cleared in phase 0, adds the returning pair in later phases and DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (r_state == ST_ISSUE && r_phase == '0) begin
      r_acc <= '0;
    end else if (r_state == ST_ISSUE || r_state == ST_DRAIN) begin
      r_acc <= w_acc_nx;
    end
  end

  // Control FSM with registered memory, result and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_idx   <= '0;
      r_w     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_load  <= 1'b0;
      r_addr1 <= '0;
      r_addr2 <= '0;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_oidx  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_w     <= weights;
            r_row   <= '0;
            r_col   <= '0;
            r_idx   <= '0;
            r_phase <= '0;
            r_busy  <= 1'b1;
            r_load  <= 1'b1;
            r_addr1 <= tap_addr('0, '0, 4'd0);
            r_addr2 <= tap_addr('0, '0, 4'd1);
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_phase == 3'(PHASES-1)) begin
            r_load  <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_phase <= w_phase_nx;
            r_addr1 <= tap_addr(r_row, r_col, w_ka_nx);
            r_addr2 <= tap_addr(r_row, r_col, w_kb_nx);
          end
        end
        ST_DRAIN: begin
          r_valid <= 1'b1;
          r_out   <= w_result;
          r_oidx  <= r_idx;
          r_state <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_row   <= w_row_nx;
              r_col   <= w_col_nx;
              r_idx   <= r_idx + 8'd1;
              r_phase <= '0;
              r_load  <= 1'b1;
              r_addr1 <= tap_addr(w_row_nx, w_col_nx, 4'd0);
              r_addr2 <= tap_addr(w_row_nx, w_col_nx, 4'd1);
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign mem_load  = r_load;
  assign mem_addr1 = r_addr1;
  assign mem_addr2 = r_addr2;
  assign out_valid = r_valid;
  assign out_data  = r_out;
  assign out_idx   = r_oidx;

endmodule
